fc_seq_ctrl: RTL and testbench

Time-multiplexed fully-connected layer engine and sequencer. It replaces the fully-unrolled 1152x10 FC datapath with a single multiply-accumulate unit and walks all output classes in turn. It issues read addresses to the flattened pooled-activation buffer and the FC weight memory. It accumulates each class sum and emits one probability word per class, then signals completion to the top-level CNN controller.

---
 rtl/fc_seq_ctrl_if.sv | 28 ++
 rtl/fc_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_fc_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_seq_ctrl_if.sv
// Memory-read and class-result bus between the FC sequencer and its surroundings.
// The master side issues addresses and produces results; the slave side returns read data.
interface fc_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned ACT_W  = 45,
  parameter int unsigned WGT_W  = 32,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CLS_W  = 4
);
  logic [ADDR_W-1:0] act_addr;
  logic [ADDR_W-1:0] wgt_addr;
  logic              rd_en;
  logic [ACT_W-1:0]  act_data;
  logic [WGT_W-1:0]  wgt_data;
  logic              prob_valid;
  logic [CLS_W-1:0]  prob_idx;
  logic [ACC_W-1:0]  prob_data;

  modport master (
    output act_addr, wgt_addr, rd_en, prob_valid, prob_idx, prob_data,
    input  act_data, wgt_data
  );

  modport slave (
    input  act_addr, wgt_addr, rd_en, prob_valid, prob_idx, prob_data,
    output act_data, wgt_data
  );
endinterface

// File: rtl/fc_seq_ctrl.sv
// Time-multiplexed fully-connected layer: one MAC walks all inputs of each class in turn,
// emitting one class sum per pass and a done pulse after the last class.
module fc_seq_ctrl #(
  parameter int unsigned N_IN   = 1152,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned ACT_W  = 45,
  parameter int unsigned WGT_W  = 32,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned CLS_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fc_enable,
  output logic          busy,
  output logic          fc_done,
  fc_seq_ctrl_if.master bus
);

  localparam int unsigned PROD_W = ACT_W + WGT_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CLS_W-1:0]  cls_q, cls_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              rd_valid_d;

  logic              rd_en_d;
  logic [ADDR_W-1:0] act_addr_d;
  logic [ADDR_W-1:0] wgt_addr_d;
  logic              prob_valid_d;
  logic [CLS_W-1:0]  prob_idx_d;
  logic [ACC_W-1:0]  prob_data_d;
  logic              busy_d;
  logic              fc_done_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      wptr_q         <= '0;
      cls_q          <= '0;
      acc_q          <= '0;
      rd_valid_d     <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.act_addr   <= '0;
      bus.wgt_addr   <= '0;
      bus.prob_valid <= 1'b0;
      bus.prob_idx   <= '0;
      bus.prob_data  <= '0;
      busy           <= 1'b0;
      fc_done        <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      wptr_q         <= wptr_d;
      cls_q          <= cls_d;
      acc_q          <= acc_d;
      rd_valid_d     <= bus.rd_en;
      bus.rd_en      <= rd_en_d;
      bus.act_addr   <= act_addr_d;
      bus.wgt_addr   <= wgt_addr_d;
      bus.prob_valid <= prob_valid_d;
      bus.prob_idx   <= prob_idx_d;
      bus.prob_data  <= prob_data_d;
      busy           <= busy_d;
      fc_done        <= fc_done_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with the state they describe.
  // The weight pointer runs continuously because class c occupies weights c*N_IN .. c*N_IN+N_IN-1.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wptr_d  = wptr_q;
    cls_d   = cls_q;
    acc_d   = rd_valid_d
              ? acc_q + ACC_W'(PROD_W'(bus.act_data) * PROD_W'(bus.wgt_data))
              : acc_q;

    case (state_q)
      IDLE: begin
        if (fc_enable) begin
          state_d = RUN;
          k_d     = '0;
          wptr_d  = '0;
          cls_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        wptr_d = wptr_q + ADDR_W'(1);
        if (k_q == ADDR_W'(N_IN - 1)) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d = WRITE;
      end
      WRITE: begin
        acc_d = '0;
        if (cls_q == CLS_W'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          cls_d   = cls_q + CLS_W'(1);
          k_d     = '0;
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_en_d      = 1'b0;
    act_addr_d   = '0;
    wgt_addr_d   = '0;
    prob_valid_d = 1'b0;
    prob_idx_d   = '0;
    prob_data_d  = '0;
    busy_d       = (state_d != IDLE);
    fc_done_d    = (state_d == DONE);

    if (state_d == RUN) begin
      rd_en_d    = 1'b1;
      act_addr_d = k_d;
      wgt_addr_d = wptr_d;
    end
    if (state_d == WRITE) begin
      prob_valid_d = 1'b1;
      prob_idx_d   = cls_d;
      prob_data_d  = acc_d;
    end
  end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Bench for fc_seq_ctrl: a small-parameter instance for directed timing/wrap/reset cases and a
// default-parameter instance run against a reference sum model.
module tb_fc_seq_ctrl;

  localparam int unsigned ACT_W  = 45;
  localparam int unsigned WGT_W  = 32;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned CLS_W  = 4;
  localparam int unsigned SN_IN  = 4;
  localparam int unsigned SN_OUT = 2;
  localparam int unsigned BN_IN  = 1152;
  localparam int unsigned BN_OUT = 10;
  localparam int SLOT = SN_IN + 2;
  localparam int SPER = SN_OUT * SLOT + 2;

  typedef struct packed {
    logic [CLS_W-1:0] idx;
    logic [ACC_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_s, en_b;
  logic busy_s, done_s, busy_b, done_b;

  fc_seq_ctrl_if #(.ADDR_W(ADDR_W), .ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .CLS_W(CLS_W)) bs ();
  fc_seq_ctrl_if #(.ADDR_W(ADDR_W), .ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .CLS_W(CLS_W)) bb ();

  fc_seq_ctrl #(.N_IN(SN_IN), .N_OUT(SN_OUT), .ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W),
                .ADDR_W(ADDR_W), .CLS_W(CLS_W)) dut_s (
    .clk(clk), .rst(rst), .fc_enable(en_s), .busy(busy_s), .fc_done(done_s), .bus(bs)
  );

  fc_seq_ctrl #(.N_IN(BN_IN), .N_OUT(BN_OUT), .ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W),
                .ADDR_W(ADDR_W), .CLS_W(CLS_W)) dut_b (
    .clk(clk), .rst(rst), .fc_enable(en_b), .busy(busy_b), .fc_done(done_b), .bus(bb)
  );

  logic [ACT_W-1:0] act_s [SN_IN];
  logic [WGT_W-1:0] wgt_s [SN_IN*SN_OUT];
  logic [ACT_W-1:0] act_b [BN_IN];
  logic [WGT_W-1:0] wgt_b [BN_IN*BN_OUT];

  // One-cycle synchronous read memories
  always @(posedge clk) begin
    if (bs.rd_en) begin
      bs.act_data <= act_s[bs.act_addr[1:0]];
      bs.wgt_data <= wgt_s[bs.wgt_addr[2:0]];
    end
    if (bb.rd_en) begin
      bb.act_data <= act_b[bb.act_addr[10:0]];
      bb.wgt_data <= wgt_b[bb.wgt_addr];
    end
  end

  int   passed = 0;
  int   total  = 0;
  exp_t q_s[$];
  exp_t q_b[$];
  int   t_s = 1000000;
  int   t_b = 1000000;
  int   len_s = 0;
  bit   mon_s = 1'b0;
  int   last_wgt_b = -1;
  int   done_t_b = -1;
  int   pv_cnt_b = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Small instance: cycle-accurate timing model plus result scoreboard
  initial begin : mon_small
    int p, c, pos;
    bit exp_rd, exp_pv;
    exp_t e;
    forever begin
      @(negedge clk);
      t_s++;
      if (bs.prob_valid) begin
        if (q_s.size() == 0) begin
          check("sb_s_unexpected_prob", 64'(1), 64'(0));
        end else begin
          e = q_s.pop_front();
          check("sb_s_idx", 64'(bs.prob_idx), 64'(e.idx));
          check("sb_s_data", 64'(bs.prob_data), 64'(e.data));
        end
      end
      if (mon_s && t_s >= 1 && t_s <= len_s) begin
        p      = (t_s - 1) % SPER;
        c      = p / SLOT;
        pos    = p % SLOT;
        exp_rd = (p < SN_OUT * SLOT) && (pos < SN_IN);
        exp_pv = (p < SN_OUT * SLOT) && (pos == SN_IN + 1);
        check("rd_en_s", 64'(bs.rd_en), 64'(exp_rd));
        check("act_addr_s", 64'(bs.act_addr), 64'(exp_rd ? pos : 0));
        check("wgt_addr_s", 64'(bs.wgt_addr), 64'(exp_rd ? c * SN_IN + pos : 0));
        check("prob_valid_s", 64'(bs.prob_valid), 64'(exp_pv));
        if (!exp_pv) begin
          check("prob_idx_zero_s", 64'(bs.prob_idx), 64'(0));
          check("prob_data_zero_s", 64'(bs.prob_data), 64'(0));
        end
        check("fc_done_s", 64'(done_s), 64'(p == SN_OUT * SLOT));
        check("busy_s", 64'(busy_s), 64'(p <= SN_OUT * SLOT));
      end
    end
  end

  // Default instance: scoreboard plus last-address and done-cycle capture
  initial begin : mon_big
    exp_t e;
    forever begin
      @(negedge clk);
      t_b++;
      if (bb.rd_en) last_wgt_b = int'(bb.wgt_addr);
      if (done_b) done_t_b = t_b;
      if (bb.prob_valid) begin
        pv_cnt_b++;
        if (q_b.size() == 0) begin
          check("sb_b_unexpected_prob", 64'(1), 64'(0));
        end else begin
          e = q_b.pop_front();
          check("sb_b_idx", 64'(bb.prob_idx), 64'(e.idx));
          check("sb_b_data", 64'(bb.prob_data), 64'(e.data));
          check("sb_b_write_cycle", 64'(t_b), 64'((int'(e.idx) + 1) * (BN_IN + 2)));
        end
      end
    end
  end

  task automatic load_s(input logic [ACT_W-1:0] a0, a1, a2, a3,
                        input logic [WGT_W-1:0] w0, w1, w2, w3, w4, w5, w6, w7);
    act_s[0] = a0; act_s[1] = a1; act_s[2] = a2; act_s[3] = a3;
    wgt_s[0] = w0; wgt_s[1] = w1; wgt_s[2] = w2; wgt_s[3] = w3;
    wgt_s[4] = w4; wgt_s[5] = w5; wgt_s[6] = w6; wgt_s[7] = w7;
  endtask

  task automatic push_s(input int idx, input logic [ACC_W-1:0] data);
    q_s.push_back('{idx: CLS_W'(idx), data: data});
  endtask

  task automatic start_s(input int len);
    @(posedge clk); #1;
    en_s  = 1'b1;
    t_s   = -1;
    len_s = len;
    mon_s = 1'b1;
    @(posedge clk); #1;
    en_s  = 1'b0;
  endtask

  task automatic wait_t_s(input int target);
    int n = 0;
    while (t_s < target && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("wait_cycle_s", 64'(t_s), 64'(target));
  endtask

  task automatic wait_done_s(input int exp_cycle);
    int n = 0;
    while (!done_s && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_seen_s", 64'(done_s), 64'(1));
    check("done_cycle_s", 64'(t_s), 64'(exp_cycle));
    @(negedge clk); #1;
    check("busy_after_done_s", 64'(busy_s), 64'(0));
  endtask

  initial begin : main
    bit seen;
    int n;
    logic [ACC_W-1:0] sum;
    logic [ACT_W+WGT_W-1:0] pr;

    // Reset held with start requested
    rst  = 1'b1;
    en_s = 1'b1;
    en_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_rd_en", 64'(bs.rd_en), 64'(0));
    check("rst_act_addr", 64'(bs.act_addr), 64'(0));
    check("rst_wgt_addr", 64'(bs.wgt_addr), 64'(0));
    check("rst_prob_valid", 64'(bs.prob_valid), 64'(0));
    check("rst_prob_idx", 64'(bs.prob_idx), 64'(0));
    check("rst_prob_data", 64'(bs.prob_data), 64'(0));
    check("rst_busy", 64'(busy_s), 64'(0));
    check("rst_done", 64'(done_s), 64'(0));
    check("rst_busy_b", 64'(busy_b), 64'(0));
    check("rst_rd_en_b", 64'(bb.rd_en), 64'(0));
    @(posedge clk); #1;
    rst  = 1'b0;
    en_s = 1'b0;

    // Basic two-class pass
    load_s(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 5);
    push_s(0, 32'd10);
    push_s(1, 32'd22);
    start_s(SPER);
    wait_done_s(13);
    wait_t_s(SPER + 1);

    // Wide activation truncation and modulo-2^32 wrap
    load_s(45'h1_0000_0001, 1, 1, 0, 3, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    push_s(0, 32'd3);
    push_s(1, 32'hFFFF_FFFE);
    start_s(SPER);
    wait_done_s(13);
    wait_t_s(SPER + 1);

    // Start pulse during class 1 RUN is ignored
    load_s(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 5);
    push_s(0, 32'd10);
    push_s(1, 32'd22);
    start_s(SPER);
    wait_t_s(8);
    en_s = 1'b1;
    @(negedge clk); #1;
    en_s = 1'b0;
    wait_done_s(13);
    wait_t_s(SPER + 1);

    // Start held high: back-to-back passes with one IDLE cycle between them
    push_s(0, 32'd10);
    push_s(1, 32'd22);
    push_s(0, 32'd10);
    push_s(1, 32'd22);
    @(posedge clk); #1;
    en_s  = 1'b1;
    t_s   = -1;
    len_s = 2 * SPER;
    mon_s = 1'b1;
    wait_t_s(16);
    en_s = 1'b0;
    wait_t_s(2 * SPER + 2);
    check("held_queue_drained", 64'(q_s.size()), 64'(0));

    // Reset mid-run aborts the pass
    push_s(0, 32'd10);
    start_s(7);
    wait_t_s(8);
    rst   = 1'b1;
    mon_s = 1'b0;
    @(negedge clk); #1;
    check("abort_rd_en", 64'(bs.rd_en), 64'(0));
    check("abort_wgt_addr", 64'(bs.wgt_addr), 64'(0));
    check("abort_act_addr", 64'(bs.act_addr), 64'(0));
    check("abort_prob_valid", 64'(bs.prob_valid), 64'(0));
    check("abort_busy", 64'(busy_s), 64'(0));
    check("abort_done", 64'(done_s), 64'(0));
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (done_s || busy_s) seen = 1'b1;
    end
    check("abort_stays_idle", 64'(seen), 64'(0));
    check("abort_queue", 64'(q_s.size()), 64'(0));
    push_s(0, 32'd10);
    push_s(1, 32'd22);
    start_s(SPER);
    wait_done_s(13);
    wait_t_s(SPER + 1);

    // Full-size pass against the reference sum model
    for (int i = 0; i < int'(BN_IN); i++) act_b[11'(i)] = ACT_W'({$urandom(), $urandom()});
    for (int i = 0; i < int'(BN_IN * BN_OUT); i++) wgt_b[14'(i)] = $urandom();
    for (int c = 0; c < int'(BN_OUT); c++) begin
      sum = '0;
      for (int k = 0; k < int'(BN_IN); k++) begin
        pr  = (ACT_W+WGT_W)'(act_b[11'(k)]) * (ACT_W+WGT_W)'(wgt_b[14'(c * int'(BN_IN) + k)]);
        sum = sum + pr[ACC_W-1:0];
      end
      q_b.push_back('{idx: CLS_W'(c), data: sum});
    end
    @(posedge clk); #1;
    en_b = 1'b1;
    t_b  = -1;
    @(posedge clk); #1;
    en_b = 1'b0;
    n = 0;
    while (!done_b && n < 12000) begin
      @(negedge clk); #1;
      n++;
    end
    check("big_done_seen", 64'(done_b), 64'(1));
    check("big_done_cycle", 64'(done_t_b), 64'(BN_OUT * (BN_IN + 2) + 1));
    check("big_last_wgt_addr", 64'(last_wgt_b), 64'(BN_IN * BN_OUT - 1));
    check("big_prob_count", 64'(pv_cnt_b), 64'(BN_OUT));
    check("big_queue_drained", 64'(q_b.size()), 64'(0));
    @(negedge clk); #1;
    check("big_busy_after", 64'(busy_b), 64'(0));
    check("small_queue_drained", 64'(q_s.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
